capture_logger: RTL and testbench

Parametrised multi-channel sample logger, successor to the single-channel fill-once BRAM logger. Captures N_CHANNELS parallel words per valid strobe into per-channel inferred block RAM. Two capture modes: immediate (fill from arm) and triggered with a configurable pre-trigger window held in a circular buffer. Sits between the TX datapath and the host log-readout path. Readout uses logical sample indices relative to the start of the capture window, so the host never sees the physical write pointer.

---
 rtl/capture_logger.sv | 197 +++++++++++++++++++
 tb/tb_capture_logger.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_logger.sv
`default_nettype none
// ============================================================================
// capture_logger - multi-channel sample logger, immediate or pre-triggered
// capture into per-channel block RAM, readout by logical window index.
// Rev 1.0
// ============================================================================
module capture_logger #(
    parameter int DATA_WIDTH = 16,
    parameter int N_CHANNELS = 2,
    parameter int DEPTH      = 1024,
    parameter int PRE_TRIG   = 256,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int CH_W      = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] i_data,
    input  logic                             i_valid,
    input  logic                             i_mode,
    input  logic                             i_run_log,
    input  logic                             i_trigger,
    input  logic                             i_read_log,
    input  logic [CH_W-1:0]                  i_read_ch,
    input  logic [ADDR_W-1:0]                i_read_addr,
    output logic [DATA_WIDTH-1:0]            o_read_data,
    output logic                             o_read_valid,
    output logic                             o_mem_full,
    output logic [2:0]                       o_state,
    output logic [ADDR_W-1:0]                o_trig_ptr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_FULL  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   c_PRE_CNT = (ADDR_W+1)'(PRE_TRIG);
    localparam logic [ADDR_W:0]   c_TGT_IMM = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_TGT_TRG = (ADDR_W+1)'(DEPTH - PRE_TRIG);
    localparam logic [ADDR_W:0]   c_ONE     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_PRE_OFS = ADDR_W'(PRE_TRIG);

    state_t              r_state;
    logic                r_run_prev;
    logic                r_armable;
    logic                r_mode;
    logic [ADDR_W-1:0]   r_wp;
    logic [ADDR_W:0]     r_cnt;
    logic                r_mem_full;
    logic [ADDR_W-1:0]   r_trig_ptr;

    logic                w_arm;
    logic                w_we;
    logic                w_rd_fire;
    logic [ADDR_W:0]     w_target;
    logic [ADDR_W:0]     w_cnt_inc;
    logic [ADDR_W-1:0]   w_start;
    logic [ADDR_W-1:0]   w_rd_phys;

    // A level held high through reset must drop before it can arm again.
    assign w_arm     = i_run_log & ~r_run_prev & r_armable &
                       ((r_state == S_IDLE) | (r_state == S_FULL));
    assign w_we      = i_valid & ((r_state == S_PRE) | (r_state == S_ARMED) | (r_state == S_POST));
    assign w_target  = r_mode ? c_TGT_TRG : c_TGT_IMM;
    assign w_cnt_inc = r_cnt + c_ONE;
    assign w_start   = r_mode ? (r_trig_ptr - c_PRE_OFS) : '0;
    assign w_rd_fire = i_read_log & (r_state == S_FULL) & ~w_arm;
    assign w_rd_phys = w_start + i_read_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_run_prev <= 1'b0;
            r_armable  <= 1'b0;
            r_mode     <= 1'b0;
            r_wp       <= '0;
            r_cnt      <= '0;
            r_mem_full <= 1'b0;
            r_trig_ptr <= '0;
        end else begin
            r_run_prev <= i_run_log;
            if (!i_run_log)
                r_armable <= 1'b1;
            if (w_we)
                r_wp <= r_wp + 1'b1;
            case (r_state)
                S_IDLE, S_FULL: begin
                    if (w_arm) begin
                        r_mode     <= i_mode;
                        r_wp       <= '0;
                        r_cnt      <= '0;
                        r_mem_full <= 1'b0;
                        if (!i_mode)
                            r_state <= S_POST;
                        else if (PRE_TRIG == 0)
                            r_state <= S_ARMED;
                        else
                            r_state <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (i_valid) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == c_PRE_CNT)
                            r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (i_valid & i_trigger) begin
                        r_trig_ptr <= r_wp;
                        r_cnt      <= c_ONE;
                        if (c_TGT_TRG == c_ONE) begin
                            r_state    <= S_FULL;
                            r_mem_full <= 1'b1;
                        end else begin
                            r_state <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (i_valid) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == w_target) begin
                            r_state    <= S_FULL;
                            r_mem_full <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read pipeline: request register, RAM output register, output register.
    logic                         r_rd_v0;
    logic                         r_rd_v1;
    logic [ADDR_W-1:0]            r_rd_addr;
    logic [CH_W-1:0]              r_rd_ch0;
    logic [CH_W-1:0]              r_rd_ch1;
    logic [N_CHANNELS*DATA_WIDTH-1:0] w_ram_q;
    logic [DATA_WIDTH-1:0]        w_rd_sel;

    for (genvar gc = 0; gc < N_CHANNELS; gc++) begin : g_ch
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [DATA_WIDTH-1:0] r_q;

        always_ff @(posedge clk) begin
            if (w_we)
                r_mem[r_wp] <= i_data[gc*DATA_WIDTH +: DATA_WIDTH];
            if (r_rd_v0)
                r_q <= r_mem[r_rd_addr];
        end

        assign w_ram_q[gc*DATA_WIDTH +: DATA_WIDTH] = r_q;
    end

    always_comb begin
        w_rd_sel = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            if (r_rd_ch1 == CH_W'(c))
                w_rd_sel = w_ram_q[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_v0      <= 1'b0;
            r_rd_v1      <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_ch0     <= '0;
            r_rd_ch1     <= '0;
            o_read_valid <= 1'b0;
            o_read_data  <= '0;
        end else begin
            r_rd_v0 <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_addr <= w_rd_phys;
                r_rd_ch0  <= i_read_ch;
            end
            r_rd_v1 <= r_rd_v0;
            if (r_rd_v0)
                r_rd_ch1 <= r_rd_ch0;
            o_read_valid <= r_rd_v1;
            if (r_rd_v1)
                o_read_data <= w_rd_sel;
        end
    end

    assign o_mem_full = r_mem_full;
    assign o_state    = r_state;
    assign o_trig_ptr = r_trig_ptr;

endmodule
`default_nettype wire

// File: tb/tb_capture_logger.sv
`default_nettype none
// ============================================================================
// tb_capture_logger - randomized directed bench with a sample-list reference
// model of the capture window. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_capture_logger;

    localparam int DW    = 16;
    localparam int NC    = 3;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;
    localparam int AW    = 4;
    localparam int CW    = 2;
    localparam int MAXS  = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NC*DW-1:0]  i_data = '0;
    logic              i_valid = 1'b0;
    logic              i_mode = 1'b0;
    logic              i_run_log = 1'b0;
    logic              i_trigger = 1'b0;
    logic              i_read_log = 1'b0;
    logic [CW-1:0]     i_read_ch = '0;
    logic [AW-1:0]     i_read_addr = '0;
    logic [DW-1:0]     o_read_data;
    logic              o_read_valid;
    logic              o_mem_full;
    logic [2:0]        o_state;
    logic [AW-1:0]     o_trig_ptr;

    always #5 clk = ~clk;

    capture_logger #(
        .DATA_WIDTH (DW),
        .N_CHANNELS (NC),
        .DEPTH      (DEPTH),
        .PRE_TRIG   (PRE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .i_mode       (i_mode),
        .i_run_log    (i_run_log),
        .i_trigger    (i_trigger),
        .i_read_log   (i_read_log),
        .i_read_ch    (i_read_ch),
        .i_read_addr  (i_read_addr),
        .o_read_data  (o_read_data),
        .o_read_valid (o_read_valid),
        .o_mem_full   (o_mem_full),
        .o_state      (o_state),
        .o_trig_ptr   (o_trig_ptr)
    );

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [DW-1:0] smp [NC][MAXS];
    bit            strg [MAXS];
    int            ns;
    logic [DW-1:0] exp_win [NC][DEPTH];
    int            exp_end;
    logic [AW-1:0] exp_tp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Build a stimulus list: ramp (ch c = c*0x100 + k) or random data and triggers.
    task automatic gen(input bit ramp, input int n, input bit mode);
        ns = n;
        for (int i = 0; i < MAXS; i++) begin
            strg[i] = 1'b0;
            for (int c = 0; c < NC; c++)
                smp[c][i] = ramp ? DW'(c*256 + i) : DW'($urandom);
            if (!ramp)
                strg[i] = ($urandom_range(0, 7) == 0);
        end
        if (!ramp && mode)
            strg[PRE + $urandom_range(0, 15)] = 1'b1;
    endtask

    // Capture window as a slice of the accepted sample list.
    task automatic model(input bit mode);
        int tidx;
        int start;
        tidx = -1;
        if (!mode) begin
            start   = 0;
            exp_end = DEPTH - 1;
            exp_tp  = '0;
        end else begin
            for (int i = PRE; i < ns; i++)
                if (strg[i] && tidx < 0)
                    tidx = i;
            start   = tidx - PRE;
            exp_end = tidx + DEPTH - PRE - 1;
            exp_tp  = AW'(tidx % DEPTH);
        end
        for (int c = 0; c < NC; c++)
            for (int j = 0; j < DEPTH; j++)
                exp_win[c][j] = smp[c][start + j];
    endtask

    task automatic arm(input bit mode, input logic [2:0] exp_st);
        i_mode    = mode;
        i_run_log = 1'b0;
        tick();
        i_run_log = 1'b1;
        tick();
        chk("arm_state", 32'(o_state), 32'(exp_st));
        chk("arm_full", 32'(o_mem_full), 32'd0);
        i_run_log = 1'b0;
    endtask

    task automatic feed(input bit gapped);
        int acc;
        int i;
        acc = 0;
        i   = 0;
        while (i < ns) begin
            if (gapped && $urandom_range(0, 1) == 1) begin
                i_valid   = 1'b0;
                i_trigger = 1'($urandom_range(0, 1));
                i_data    = (NC*DW)'({$urandom(), $urandom()});
                tick();
            end else begin
                i_valid   = 1'b1;
                i_trigger = strg[i];
                for (int c = 0; c < NC; c++)
                    i_data[c*DW +: DW] = smp[c][i];
                tick();
                i++;
                acc = i;
            end
            chk("mem_full_track", 32'(o_mem_full), 32'(acc - 1 >= exp_end));
        end
        i_valid   = 1'b0;
        i_trigger = 1'b0;
    endtask

    task automatic readback();
        logic [DW-1:0] expv;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < DEPTH + 2; k++) begin
                if (k < DEPTH) begin
                    i_read_log  = 1'b1;
                    i_read_ch   = CW'(c);
                    i_read_addr = AW'(k);
                end else begin
                    i_read_log = 1'b0;
                end
                tick();
                if (k >= 2) begin
                    expv = '0;
                    if (c < NC)
                        expv = exp_win[c][k-2];
                    chk("rd_valid", 32'(o_read_valid), 32'd1);
                    chk($sformatf("rd_data_ch%0d_a%0d", c, k-2), 32'(o_read_data), 32'(expv));
                end
            end
        end
        tick();
        chk("rd_valid_idle", 32'(o_read_valid), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_full", 32'(o_mem_full), 32'd0);
        chk("rst_valid", 32'(o_read_valid), 32'd0);
        chk("rst_data", 32'(o_read_data), 32'd0);
        chk("rst_tptr", 32'(o_trig_ptr), 32'd0);

        // Reads outside FULL are dropped.
        i_read_log = 1'b1;
        tick();
        i_read_log = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("idle_read_valid", 32'(o_read_valid), 32'd0);
            tick();
        end

        // Immediate capture, directed ramp.
        gen(1'b1, 16, 1'b0);
        model(1'b0);
        arm(1'b0, 3'd3);
        feed(1'b0);
        chk("imm_state_full", 32'(o_state), 32'd4);
        i_read_log = 1'b1; i_read_ch = 2'd1; i_read_addr = 4'd5;
        tick();
        i_read_log = 1'b0;
        tick();
        chk("ch1_a5_early", 32'(o_read_valid), 32'd0);
        tick();
        chk("ch1_a5_valid", 32'(o_read_valid), 32'd1);
        chk("ch1_a5_data", 32'(o_read_data), 32'h105);
        readback();

        // Triggered with wrap; triggers during PRE must be ignored.
        gen(1'b1, 34, 1'b1);
        strg[1]  = 1'b1;
        strg[3]  = 1'b1;
        strg[20] = 1'b1;
        model(1'b1);
        arm(1'b1, 3'd1);
        feed(1'b0);
        chk("trg_state_full", 32'(o_state), 32'd4);
        chk("trg_ptr", 32'(o_trig_ptr), 32'(exp_tp));
        chk("trg_ptr_const", 32'(o_trig_ptr), 32'd4);
        readback();

        // Asynchronous reset in the middle of POST.
        arm(1'b0, 3'd3);
        i_run_log = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            i_data  = (NC*DW)'(k);
            tick();
        end
        i_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_state", 32'(o_state), 32'd0);
        chk("mid_rst_full", 32'(o_mem_full), 32'd0);
        chk("mid_rst_valid", 32'(o_read_valid), 32'd0);
        chk("mid_rst_data", 32'(o_read_data), 32'd0);
        chk("mid_rst_tptr", 32'(o_trig_ptr), 32'd0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("held_run_no_arm", 32'(o_state), 32'd0);
        end
        i_run_log = 1'b0;
        tick();
        i_run_log = 1'b1;
        tick();
        chk("rearm_after_low", 32'(o_state), 32'd3);
        i_run_log = 1'b0;
        gen(1'b0, 20, 1'b0);
        model(1'b0);
        feed(1'b0);
        chk("post_rst_full", 32'(o_state), 32'd4);
        readback();

        // Randomized captures, later ones with gapped valid.
        for (int it = 0; it < 4; it++) begin
            gen(1'b0, (it % 2 == 1) ? 40 : 20, 1'(it % 2));
            model(1'(it % 2));
            arm(1'(it % 2), (it % 2 == 1) ? 3'd1 : 3'd3);
            feed(it >= 2);
            chk("rnd_state_full", 32'(o_state), 32'd4);
            if (it % 2 == 1)
                chk("rnd_trg_ptr", 32'(o_trig_ptr), 32'(exp_tp));
            readback();
        end

        // Arm edge colliding with a read request in FULL.
        i_mode     = 1'b0;
        i_run_log  = 1'b1;
        i_read_log = 1'b1;
        i_read_ch  = 2'd0;
        tick();
        i_read_log = 1'b0;
        chk("coll_state", 32'(o_state), 32'd3);
        chk("coll_full_low", 32'(o_mem_full), 32'd0);
        tick();
        chk("coll_valid_1", 32'(o_read_valid), 32'd0);
        tick();
        chk("coll_valid_2", 32'(o_read_valid), 32'd0);
        i_run_log = 1'b0;
        gen(1'b0, 16, 1'b0);
        model(1'b0);
        feed(1'b1);
        chk("coll_cap_full", 32'(o_state), 32'd4);
        readback();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
